// File: rtl/sonar_array_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sonar_array_if
// Signal bundle between the sonar controller, the sonar connector pins and
// the obstacle-detection logic. Names are seen from the controller side.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface sonar_array_if #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 20
) ();
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                    enable_i;
  logic [N_CH-1:0]         ch_mask_i;
  logic [N_CH-1:0]         echo_i;
  logic [N_CH-1:0]         trig_o;
  logic [N_CH*CNT_W-1:0]   range_o;
  logic [N_CH-1:0]         valid_o;
  logic [N_CH-1:0]         timeout_o;
  logic [CH_W-1:0]         cur_ch_o;

  // Controller side
  modport slave (
    input  enable_i, ch_mask_i, echo_i,
    output trig_o, range_o, valid_o, timeout_o, cur_ch_o
  );

  // Environment side (control logic and sonar pins)
  modport master (
    output enable_i, ch_mask_i, echo_i,
    input  trig_o, range_o, valid_o, timeout_o, cur_ch_o
  );
endinterface
`default_nettype wire

// File: rtl/sonar_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sonar_array
// Round-robin multi-channel ultrasonic ranging controller. Fires one sonar per
// slot, blanks the trigger ring-down, then measures the echo pulse width.
// Revision: 1.0
// ---------------------------------------------------------------------------
module sonar_array #(
  parameter int N_CH          = 3,
  parameter int CNT_W         = 20,
  parameter int TRIG_CYCLES   = 500,
  parameter int BLANK_CYCLES  = 10000,
  parameter int PERIOD_CYCLES = 882400
) (
  input  logic         clk,
  input  logic         rst_n,
  sonar_array_if.slave bus
);
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SLOT_W = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(PERIOD_CYCLES - 1);
  localparam logic [SLOT_W-1:0] TRIG_LAST  = SLOT_W'(TRIG_CYCLES - 1);
  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(TRIG_CYCLES + BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRIG    = 3'd1,
    S_BLANK   = 3'd2,
    S_ARMED   = 3'd3,
    S_MEASURE = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [CNT_W-1:0]      width_q, width_d;
  logic [CH_W-1:0]       cur_ch_q, cur_ch_d;
  logic [N_CH*CNT_W-1:0] range_q, range_d;
  logic [N_CH-1:0]       timeout_q, timeout_d;
  logic [N_CH-1:0]       valid_q, valid_d;

  logic [N_CH-1:0]       echo_s1_q, echo_s2_q, echo_s3_q;
  logic                  rise_c, fall_c, echo_hi_c;
  logic [CH_W-1:0]       lo_ch_c, hi_ch_c, nxt_ch_c;
  logic                  hi_found_c;
  logic [N_CH-1:0]       trig_c;

  // Two-flop synchroniser plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_s1_q <= '0;
      echo_s2_q <= '0;
      echo_s3_q <= '0;
    end else begin
      echo_s1_q <= bus.echo_i;
      echo_s2_q <= echo_s1_q;
      echo_s3_q <= echo_s2_q;
    end
  end

  assign echo_hi_c = echo_s2_q[cur_ch_q];
  assign rise_c    = echo_s2_q[cur_ch_q] & ~echo_s3_q[cur_ch_q];
  assign fall_c    = ~echo_s2_q[cur_ch_q] & echo_s3_q[cur_ch_q];

  // Lowest set mask bit, and the next set bit above cur_ch (wrapping to lowest)
  always_comb begin
    lo_ch_c    = '0;
    hi_ch_c    = '0;
    hi_found_c = 1'b0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (bus.ch_mask_i[j]) lo_ch_c = CH_W'(j);
      if (bus.ch_mask_i[j] && (j > int'(cur_ch_q))) begin
        hi_ch_c    = CH_W'(j);
        hi_found_c = 1'b1;
      end
    end
    nxt_ch_c = hi_found_c ? hi_ch_c : lo_ch_c;
  end

  // State, slot counter, width counter and published results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      slot_q    <= '0;
      width_q   <= '0;
      cur_ch_q  <= '0;
      range_q   <= '0;
      timeout_q <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      width_q   <= width_d;
      cur_ch_q  <= cur_ch_d;
      range_q   <= range_d;
      timeout_q <= timeout_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state logic: abort beats slot end, slot end beats in-slot transitions
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    width_d   = width_q;
    cur_ch_d  = cur_ch_q;
    range_d   = range_q;
    timeout_d = timeout_q;
    valid_d   = '0;

    if (state_q == S_IDLE) begin
      slot_d = '0;
      if (bus.enable_i && (|bus.ch_mask_i)) begin
        state_d  = S_TRIG;
        cur_ch_d = lo_ch_c;
      end
    end else if (!bus.enable_i) begin
      state_d = S_IDLE;
      slot_d  = '0;
    end else if (slot_q == SLOT_LAST) begin
      valid_d[cur_ch_q] = 1'b1;
      // A falling edge on the very last cycle still counts as a completed echo
      if ((state_q == S_DONE) || ((state_q == S_MEASURE) && fall_c)) begin
        range_d[int'(cur_ch_q)*CNT_W +: CNT_W] = width_q;
        timeout_d[cur_ch_q]                    = 1'b0;
      end else begin
        range_d[int'(cur_ch_q)*CNT_W +: CNT_W] = CNT_MAX;
        timeout_d[cur_ch_q]                    = 1'b1;
      end
      slot_d = '0;
      if (|bus.ch_mask_i) begin
        state_d  = S_TRIG;
        cur_ch_d = nxt_ch_c;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      slot_d = slot_q + SLOT_W'(1);
      case (state_q)
        S_TRIG:  if (slot_q == TRIG_LAST)  state_d = S_BLANK;
        S_BLANK: if (slot_q == BLANK_LAST) state_d = S_ARMED;
        S_ARMED: begin
          if (rise_c) begin
            state_d = S_MEASURE;
            width_d = CNT_W'(1);
          end
        end
        S_MEASURE: begin
          if (fall_c) begin
            state_d = S_DONE;
          end else if (echo_hi_c && (width_q != CNT_MAX)) begin
            width_d = width_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Trigger drives only the channel owning the slot, only during S_TRIG
  always_comb begin
    trig_c = '0;
    if (state_q == S_TRIG) trig_c[cur_ch_q] = 1'b1;
  end

  assign bus.trig_o    = trig_c;
  assign bus.range_o   = range_q;
  assign bus.valid_o   = valid_q;
  assign bus.timeout_o = timeout_q;
  assign bus.cur_ch_o  = cur_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_sonar_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sonar_array
// Directed bench with a result scoreboard for two sonar_array instances:
// a 12-bit main instance and a 6-bit instance for saturation cases.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_sonar_array;
  logic clk;
  logic rst_n;

  sonar_array_if #(.N_CH(3), .CNT_W(12)) bus  ();
  sonar_array_if #(.N_CH(3), .CNT_W(6))  bus2 ();

  sonar_array #(.N_CH(3), .CNT_W(12), .TRIG_CYCLES(5), .BLANK_CYCLES(10),
                .PERIOD_CYCLES(200)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  sonar_array #(.N_CH(3), .CNT_W(6), .TRIG_CYCLES(5), .BLANK_CYCLES(10),
                .PERIOD_CYCLES(200)) u_sat (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int ch; int rng; bit to; } exp_t;
  exp_t q_main[$];
  exp_t q_sat[$];

  int n_vec  = 0;
  int n_fail = 0;
  int slot_cyc = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_main(int ch, int rng, bit to);
    exp_t e;
    e.ch = ch; e.rng = rng; e.to = to;
    q_main.push_back(e);
  endtask

  task automatic push_sat(int ch, int rng, bit to);
    exp_t e;
    e.ch = ch; e.rng = rng; e.to = to;
    q_sat.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
    slot_cyc += n;
  endtask

  task automatic go(int k);
    if (k > slot_cyc) step(k - slot_cyc);
  endtask

  task automatic next_slot(logic [2:0] exp_trig, string name);
    go(200);
    chk(name, bus.trig_o, exp_trig);
    slot_cyc = 0;
  endtask

  // Scoreboard monitor: every valid bit must match the oldest expected result
  always @(negedge clk) begin
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      if (bus.valid_o[c]) begin
        n_vec++;
        if (q_main.size() == 0) begin
          n_fail++;
          $display("FAIL main_unexpected_valid: ch=%0d range=%0d timeout=%0b expected no result",
                   c, bus.range_o[c*12 +: 12], bus.timeout_o[c]);
        end else begin
          e = q_main.pop_front();
          if (e.ch != c || int'(bus.range_o[c*12 +: 12]) != e.rng || bus.timeout_o[c] != e.to) begin
            n_fail++;
            $display("FAIL main_result: got ch=%0d range=%0d timeout=%0b expected ch=%0d range=%0d timeout=%0b",
                     c, bus.range_o[c*12 +: 12], bus.timeout_o[c], e.ch, e.rng, e.to);
          end
        end
      end
      if (bus2.valid_o[c]) begin
        n_vec++;
        if (q_sat.size() == 0) begin
          n_fail++;
          $display("FAIL sat_unexpected_valid: ch=%0d range=%0d timeout=%0b expected no result",
                   c, bus2.range_o[c*6 +: 6], bus2.timeout_o[c]);
        end else begin
          e = q_sat.pop_front();
          if (e.ch != c || int'(bus2.range_o[c*6 +: 6]) != e.rng || bus2.timeout_o[c] != e.to) begin
            n_fail++;
            $display("FAIL sat_result: got ch=%0d range=%0d timeout=%0b expected ch=%0d range=%0d timeout=%0b",
                     c, bus2.range_o[c*6 +: 6], bus2.timeout_o[c], e.ch, e.rng, e.to);
          end
        end
      end
    end
  end

  initial begin
    int hi;
    rst_n = 1'b0;
    bus.enable_i  = 1'b0; bus.ch_mask_i  = '0; bus.echo_i  = '0;
    bus2.enable_i = 1'b0; bus2.ch_mask_i = '0; bus2.echo_i = '0;
    step(3);
    chk("reset_trig",    bus.trig_o,    0);
    chk("reset_range",   bus.range_o,   0);
    chk("reset_valid",   bus.valid_o,   0);
    chk("reset_timeout", bus.timeout_o, 0);
    chk("reset_cur_ch",  bus.cur_ch_o,  0);
    rst_n = 1'b1;
    step(2);

    // S1 ch0: 37-cycle echo at slot cycle 40
    bus.ch_mask_i = 3'b111;
    bus.enable_i  = 1'b1;
    step(1);
    chk("s1_first_trig", bus.trig_o, 3'b001);
    slot_cyc = 0;
    hi = 1;
    for (int i = 1; i < 10; i++) begin
      step(1);
      if (bus.trig_o[0]) hi++;
    end
    chk("s1_trig_len", hi, 5);
    chk("s1_cur_ch", bus.cur_ch_o, 0);
    go(40);  bus.echo_i[0] = 1'b1;
    go(77);  bus.echo_i[0] = 1'b0;
    push_main(0, 37, 1'b0);
    go(199);
    chk("s1_trig_before_end",  bus.trig_o,  0);
    chk("s1_valid_before_end", bus.valid_o, 0);
    next_slot(3'b010, "s2_trig");
    chk("s1_valid_with_trig1", bus.valid_o, 3'b001);

    // S2 ch1: pulse inside blanking only -> timeout
    go(8);   bus.echo_i[1] = 1'b1;
    go(13);  bus.echo_i[1] = 1'b0;
    push_main(1, 4095, 1'b1);
    go(100);
    chk("s2_cur_ch", bus.cur_ch_o, 1);
    next_slot(3'b100, "s3_trig");

    // S3 ch2: blanked pulse then 20-cycle pulse at 50
    go(8);   bus.echo_i[2] = 1'b1;
    go(13);  bus.echo_i[2] = 1'b0;
    go(50);  bus.echo_i[2] = 1'b1;
    go(70);  bus.echo_i[2] = 1'b0;
    push_main(2, 20, 1'b0);
    next_slot(3'b001, "s4_trig");

    // S4 ch0: no echo, mask changes to 101 mid-slot
    push_main(0, 4095, 1'b1);
    go(100); bus.ch_mask_i = 3'b101;
    next_slot(3'b100, "s5_trig_skip1");

    // S5 ch2: 15-cycle echo
    go(60);  bus.echo_i[2] = 1'b1;
    go(75);  bus.echo_i[2] = 1'b0;
    push_main(2, 15, 1'b0);
    next_slot(3'b001, "s6_trig");

    // S6 ch0: 11-cycle echo
    go(30);  bus.echo_i[0] = 1'b1;
    go(41);  bus.echo_i[0] = 1'b0;
    push_main(0, 11, 1'b0);
    next_slot(3'b100, "s7_trig");

    // S7 ch2: measured pulse then abort at slot cycle 100
    go(40);  bus.echo_i[2] = 1'b1;
    go(50);  bus.echo_i[2] = 1'b0;
    go(100); bus.enable_i = 1'b0;
    step(1);
    chk("abort_trig", bus.trig_o, 0);
    chk("abort_range", bus.range_o, {12'd15, 12'd4095, 12'd11});
    step(150);
    chk("abort_range_held", bus.range_o, {12'd15, 12'd4095, 12'd11});
    chk("abort_timeout_held", bus.timeout_o, 3'b010);
    bus.enable_i = 1'b1;
    step(1);
    chk("reenable_trig", bus.trig_o, 3'b001);
    slot_cyc = 0;

    // S8 ch0: reset in the middle of a measurement
    go(30);  bus.echo_i[0] = 1'b1;
    go(50);
    rst_n = 1'b0;
    #1;
    chk("rst_trig",    bus.trig_o,    0);
    chk("rst_range",   bus.range_o,   0);
    chk("rst_valid",   bus.valid_o,   0);
    chk("rst_timeout", bus.timeout_o, 0);
    chk("rst_cur_ch",  bus.cur_ch_o,  0);
    bus.echo_i[0] = 1'b0;
    bus.ch_mask_i = 3'b110;
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_trig", bus.trig_o, 3'b010);
    chk("post_rst_cur_ch", bus.cur_ch_o, 1);
    bus.enable_i = 1'b0;
    step(5);

    // Saturation instance: ch0 only, re-fires every slot
    bus2.ch_mask_i = 3'b001;
    bus2.enable_i  = 1'b1;
    step(1);
    chk("sat_first_trig", bus2.trig_o, 3'b001);
    slot_cyc = 0;
    go(20);  bus2.echo_i[0] = 1'b1;
    push_sat(0, 63, 1'b1);
    go(200);
    chk("sat_refire_trig", bus2.trig_o, 3'b001);
    slot_cyc = 0;
    bus2.echo_i[0] = 1'b0;
    go(20);  bus2.echo_i[0] = 1'b1;
    go(197); bus2.echo_i[0] = 1'b0;
    push_sat(0, 63, 1'b0);
    go(200);
    chk("sat_refire_trig2", bus2.trig_o, 3'b001);
    bus2.enable_i = 1'b0;
    step(5);

    chk("main_queue_drained", q_main.size(), 0);
    chk("sat_queue_drained",  q_sat.size(),  0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sonar_array.md
# sonar_array

Parametrised multi-channel ultrasonic ranging controller, the successor to the fixed three-sonar sequencer. It fires one sonar at a time in round-robin order, skipping channels masked off at run time, and measures each echo pulse width in clock cycles with edge-qualified, blanking-protected capture. Each published result carries a one-cycle valid strobe and a per-channel timeout flag. It sits between the sonar connector pins and the obstacle-detection logic.

## Interface
- N_CH, 3: number of sonar channels (≥1)
- CNT_W, 20: width of each range result
- TRIG_CYCLES, 500: trigger pulse length in cycles (10 µs at 50 MHz)
- BLANK_CYCLES, 10000: cycles after trigger end during which echo edges are ignored
- PERIOD_CYCLES, 882400: slot length per channel, from trigger rise to the next trigger (6 m round trip at 340 m/s, 50 MHz)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run control; low aborts and idles
- ch_mask  in  N_CH  1 = channel participates in the rotation
- echo  in  N_CH  raw echo inputs, asynchronous
- trig  out  N_CH  trigger outputs, at most one high at a time
- range  out  N_CH*CNT_W  latest result per channel; channel i at bits [i*CNT_W +: CNT_W]
- valid  out  N_CH  one-cycle strobe when range[i] updates
- timeout  out  N_CH  set with valid when channel i saw no complete echo
- cur_ch  out  $clog2(N_CH) (min 1)  channel owning the current slot

## Operation
- Echo inputs pass through a 2-FF synchroniser. Edges are detected on the synchronised signal.
- FSM states:
  - IDLE: trig=0.
  - TRIG: trig[cur_ch]=1.
  - BLANK.
  - ARMED: waiting for a rising edge.
  - MEASURE: counting cycles while echo is high.
  - DONE: holding until the slot ends.
- A slot counter runs from 0 to PERIOD_CYCLES-1 in every non-IDLE state.
- IDLE→TRIG happens when enable=1 and ch_mask≠0. cur_ch is set to the lowest-indexed set mask bit.
- TRIG→BLANK when the slot counter reaches TRIG_CYCLES. BLANK→ARMED after BLANK_CYCLES further cycles.
- ARMED→MEASURE on a rising edge. The width counter loads 1.
- In MEASURE the counter increments each cycle echo stays high and saturates at 2^CNT_W−1. A falling edge moves the FSM to DONE.
- Echo edges seen in TRIG, BLANK or DONE are ignored. An echo that is already high when the FSM enters ARMED does not count as a rising edge.
- At slot end (counter = PERIOD_CYCLES−1), the channel result is registered:
  - From DONE: range = width, timeout = 0.
  - From ARMED or MEASURE: range = all ones, timeout = 1.
  - In both cases valid[cur_ch] pulses.
- Next channel is the next set bit of ch_mask after cur_ch, wrapping around. ch_mask is sampled only at slot end.
  - If ch_mask = 0 at slot end, the block goes to IDLE.
  - If only cur_ch is set, the same channel re-fires.
- enable low mid-slot: go to IDLE on the next cycle, trig = 0, no valid; range/timeout keep their previous values.
- A falling edge on the last slot cycle completes the measurement (result from DONE).
- Reset asserted mid-operation: all state clears immediately.

## Timing
- Reset values: trig=0, range=0, valid=0, timeout=0, cur_ch=0, FSM=IDLE.
- Slot cycle 0 is the first cycle trig is high. trig is high for exactly TRIG_CYCLES cycles.
- First trigger comes one cycle after enable is sampled high in IDLE.
- Echo-to-edge-detect latency is 2 cycles, so measured width equals the raw pulse width in cycles (±0 for synchronous stimulus).
- range, timeout and valid update in the cycle after slot cycle PERIOD_CYCLES−1. That is the same cycle the next channel's trig rises, so trigger-to-trigger spacing is exactly PERIOD_CYCLES.
- valid is high for exactly one cycle per completed slot. Aborted slots produce none.

## Test plan
Bench parameters: N_CH=3, CNT_W=12, TRIG_CYCLES=5, BLANK_CYCLES=10, PERIOD_CYCLES=200.
- Basic measurement: enable=1, mask=3'b111, echo0 high for 37 cycles starting at slot cycle 40 → trig0 high 5 cycles; range[0]=37, timeout[0]=0, valid[0] pulses at slot cycle 200; trig1 rises in that same cycle.
- Blanking: echo1 pulse at slot cycles 8–12, then no echo → range[1]=4095, timeout[1]=1. Variant: a second pulse of 20 cycles at cycle 50 gives range[1]=20.
- Mask skip: mask=3'b101 → trig sequence 0, 2, 0, 2 with 200-cycle spacing; valid[1] never asserts.
- Saturation with CNT_W=6: echo held high from cycle 20 to the end of the slot → range=63, timeout=1 (no falling edge). Variant: falling edge exactly on slot cycle 199 → range=63, timeout=0.
- Abort: enable dropped at slot cycle 100 → trig=0 and FSM=IDLE the next cycle; no valid; range unchanged. Re-enable → trig0 rises one cycle later.
- Reset: reset low mid-MEASURE → all outputs 0 asynchronously; after release with enable=1, the first trigger goes to the lowest enabled channel.
